// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage-register enables, bubble/flush injection,
// data-memory freeze, fetch-response discard after redirect, stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_redirect,
    input  logic             imem_pending,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             imem_hold,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, DMEM_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_n;
    logic   discard;
    logic   discard_n;
    logic   frozen;
    logic   load_use;

    // Freeze covers both the first stalled cycle in RUN and every waiting cycle.
    always_comb begin
        frozen = ((state == RUN) && dmem_req && !dmem_resp)
              || ((state == DMEM_WAIT) && !dmem_resp);
        load_use = ex_valid && ex_mem_read && (ex_rd_s != 5'd0) && id_valid
                && ((ex_rd_s == id_rs1_s) || (ex_rd_s == id_rs2_s));
    end

    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        imem_hold   = 1'b0;
        state_n     = frozen ? DMEM_WAIT : RUN;
        discard_n   = discard;

        if (rst) begin
            state_n   = RUN;
            discard_n = 1'b0;
        end else if (frozen) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
            imem_hold = 1'b1;
        end else begin
            if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!imem_resp) begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end

            // A stale fetch in flight is squashed until it returns; a redirect still moves the PC.
            if (discard && !ex_redirect) begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end
            if (discard && imem_resp) begin
                discard_n = 1'b0;
            end
            if (ex_redirect && imem_pending && !imem_resp) begin
                discard_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            discard     <= 1'b0;
            stall_count <= '0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (!pc_we && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected enable/flush vectors queued
// as stimulus is applied, popped and compared mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush, imem_hold}
    localparam logic [7:0] E_RUN    = 8'b11111_000;
    localparam logic [7:0] E_LDUSE  = 8'b00111_010;
    localparam logic [7:0] E_FREEZE = 8'b00000_001;
    localparam logic [7:0] E_REDIR  = 8'b11111_110;
    localparam logic [7:0] E_FMISS  = 8'b01111_100;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1_s;
    logic [4:0]       id_rs2_s;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd_s;
    logic             ex_redirect;
    logic             imem_pending;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             imem_hold;
    logic [CNT_W-1:0] stall_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned exp_cnt  = 0;
    logic [7:0]  exp_q[$];

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_s(id_rs1_s), .id_rs2_s(id_rs2_s),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_s(ex_rd_s),
        .ex_redirect(ex_redirect), .imem_pending(imem_pending), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .imem_hold(imem_hold), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_id_flush, id_ex_flush, imem_hold};
    endfunction

    task automatic set_idle();
        id_valid     = 1'b0;
        id_rs1_s     = 5'd0;
        id_rs2_s     = 5'd0;
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd_s      = 5'd0;
        ex_redirect  = 1'b0;
        imem_pending = 1'b0;
        imem_resp    = 1'b1;
        dmem_req     = 1'b0;
        dmem_resp    = 1'b0;
    endtask

    // Queue the expected vector for the inputs now applied, compare mid-cycle, advance.
    task automatic step(input string name, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL %s outputs: got %b expected %b", name, obs_vec(), e);
        end
        checks++;
        if (stall_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL %s stall_count: got %0d expected %0d", name, stall_count, exp_cnt);
        end
        if (rst) exp_cnt = 0;
        else if (!e[7] && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        dmem_req    = 1'b1;
        ex_redirect = 1'b1;
        imem_resp   = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== E_RUN || stall_count !== '0) begin
            failures++;
            $display("FAIL reset_async: got %b cnt %0d expected %b cnt 0", obs_vec(), stall_count, E_RUN);
        end
        @(posedge clk);
        #1;
        step("reset_hold", E_RUN);
        rst = 1'b0;
        set_idle();
        step("after_reset", E_RUN);
    endtask

    task automatic test_load_use();
        set_idle();
        id_valid = 1'b1; id_rs2_s = 5'd5; id_rs1_s = 5'd3;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_s = 5'd5;
        step("load_use", E_LDUSE);
        set_idle();
        id_valid = 1'b1; id_rs1_s = 5'd5; ex_valid = 1'b1; ex_rd_s = 5'd9;
        step("load_use_next", E_RUN);
        set_idle();
        id_valid = 1'b1; ex_valid = 1'b1; ex_mem_read = 1'b1;
        step("load_use_x0", E_RUN);
        id_rs1_s = 5'd7; ex_rd_s = 5'd7; id_valid = 1'b0;
        step("load_use_id_invalid", E_RUN);
        id_valid = 1'b1; ex_mem_read = 1'b0;
        step("alu_no_stall", E_RUN);
    endtask

    task automatic test_priority();
        set_idle();
        imem_resp = 1'b0;
        step("fetch_miss", E_FMISS);
        id_valid = 1'b1; id_rs1_s = 5'd12; ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_s = 5'd12;
        step("load_use_over_fmiss", E_LDUSE);
        ex_redirect = 1'b1;
        step("redirect_over_load_use", E_REDIR);
        dmem_req = 1'b1; dmem_resp = 1'b1;
        step("dmem_hit_same_cycle", E_REDIR);
        set_idle();
        step("priority_idle", E_RUN);
    endtask

    task automatic test_dmem_wait();
        set_idle();
        dmem_req = 1'b1; ex_redirect = 1'b1;
        step("dmem_freeze0", E_FREEZE);
        step("dmem_freeze1", E_FREEZE);
        step("dmem_freeze2", E_FREEZE);
        dmem_resp = 1'b1;
        step("dmem_exit_redirect", E_REDIR);
        set_idle();
        step("dmem_after", E_RUN);
    endtask

    task automatic test_discard();
        set_idle();
        ex_redirect = 1'b1; imem_pending = 1'b1; imem_resp = 1'b0;
        step("discard_redirect", E_REDIR);
        ex_redirect = 1'b0;
        step("discard_wait", E_FMISS);
        imem_resp = 1'b1;
        step("discard_drop", E_FMISS);
        imem_pending = 1'b0;
        step("discard_cleared", E_RUN);
    endtask

    task automatic test_back_to_back();
        set_idle();
        ex_redirect = 1'b1; imem_pending = 1'b1; imem_resp = 1'b0;
        step("b2b_redirect0", E_REDIR);
        step("b2b_redirect1", E_REDIR);
        ex_redirect = 1'b0; dmem_req = 1'b1; imem_resp = 1'b1;
        step("b2b_discard_frozen", E_FREEZE);
        dmem_resp = 1'b1; imem_resp = 1'b0;
        step("b2b_discard_survives", E_FMISS);
        set_idle();
        step("b2b_drop", E_FMISS);
        step("b2b_normal", E_RUN);
    endtask

    task automatic test_saturate();
        set_idle();
        imem_resp = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        exp_cnt = 65535;
        checks++;
        if (stall_count !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL saturate: got %0d expected %0d", stall_count, exp_cnt);
        end
        step("saturate_hold", E_FMISS);
        set_idle();
        step("saturate_exit", E_RUN);
    endtask

    task automatic test_async_reset_mid_wait();
        set_idle();
        ex_redirect = 1'b1; imem_pending = 1'b1; imem_resp = 1'b0;
        step("rst_mid_redirect", E_REDIR);
        ex_redirect = 1'b0; dmem_req = 1'b1;
        step("rst_mid_freeze0", E_FREEZE);
        step("rst_mid_freeze1", E_FREEZE);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== E_RUN || stall_count !== '0) begin
            failures++;
            $display("FAIL async_reset_mid_wait: got %b cnt %0d expected %b cnt 0", obs_vec(), stall_count, E_RUN);
        end
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        step("post_reset_run", E_RUN);
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        #2;
        test_reset();
        test_load_use();
        test_priority();
        test_dmem_wait();
        test_discard();
        test_back_to_back();
        test_saturate();
        test_async_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of stall performance counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_valid  in  1  IF/ID holds a valid instruction.
REQ-005 id_rs1_s, id_rs2_s  in  5 each  decode-stage source registers, 0 when unused.
REQ-006 ex_valid, ex_mem_read  in  1 each  EX holds valid instruction; it is a load.
REQ-007 ex_rd_s  in  5  EX destination, 0 for store/branch.
REQ-008 ex_redirect  in  1  EX resolved mispredict/jump; PC must take new target.
REQ-009 imem_pending, imem_resp  in  1 each  fetch outstanding; fetch data valid this cycle.
REQ-010 dmem_req, dmem_resp  in  1 each  MEM stage issuing/awaiting access; data memory done.
REQ-011 pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load bubble into that register on its next write.
REQ-013 imem_hold  out  1  fetch unit holds any returned response.
REQ-014 stall_count  out  CNT_W  saturating count of cycles with pc_we=0.

Function
REQ-015 FSM states: RUN, DMEM_WAIT; plus independent 1-bit discard flag.
REQ-016 RUN defaults: all *_we=1, flushes=0, imem_hold=0.
REQ-017 Priority in RUN: dmem stall > redirect > load-use > fetch miss.
REQ-018 dmem stall: RUN with dmem_req=1, dmem_resp=0 -> all *_we=0, flushes=0, imem_hold=1; next state DMEM_WAIT.
REQ-019 DMEM_WAIT, dmem_resp=0: all *_we=0, flushes=0, imem_hold=1; redirect/load-use not evaluated.
REQ-020 DMEM_WAIT, dmem_resp=1: next state RUN; outputs this cycle per RUN rules with dmem stall term suppressed.
REQ-021 redirect (ex_redirect=1, no dmem stall): pc_we=1, if_id_flush=1, id_ex_flush=1; if imem_pending=1 and imem_resp=0, set discard.
REQ-022 load-use: ex_valid & ex_mem_read & ex_rd_s!=0 & id_valid & (ex_rd_s==id_rs1_s | ex_rd_s==id_rs2_s) -> pc_we=0, if_id_we=0, id_ex_flush=1; exactly one cycle per hazard, since the load leaves EX.
REQ-023 fetch miss: imem_resp=0 in RUN, no higher-priority event -> pc_we=0, if_id_flush=1; back-end enables stay 1.
REQ-024 discard set: if_id_flush=1 and pc_we=0 every non-frozen cycle; cleared on first imem_resp (that response dropped, never written to IF/ID).
REQ-025 discard and dmem stall coincide: freeze rules (REQ-018/019) win; discard still clears on imem_resp only when imem_hold=0.
REQ-026 New redirect while discard set: discard stays set; no second discard tracked.
REQ-027 stall_count increments by 1 on each cycle with pc_we=0; holds at 2^CNT_W-1.
REQ-028 Outputs combinational from state, discard, inputs; no input-to-output latency beyond same cycle.

Reset
REQ-029 rst=1: state=RUN, discard=0, stall_count=0, immediately regardless of clk.
REQ-030 During reset, outputs equal RUN defaults with all inputs ignored (*_we=1, flushes=0, imem_hold=0).
REQ-031 Reset mid-DMEM_WAIT or with discard set abandons both; first post-reset cycle follows RUN rules.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_rd_s=5, id_rs2_s=5, valid both -> one cycle pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all we=1; stall_count=1.
REQ-033 ex_rd_s=0 with matching id_rs1_s=0 and ex_mem_read=1 -> no stall.
REQ-034 dmem_req=1, dmem_resp after 3 cycles -> 3 cycles all *_we=0, imem_hold=1; 4th cycle RUN outputs; concurrent ex_redirect applied only on exit cycle.
REQ-035 ex_redirect with imem_pending=1, imem_resp=0; imem_resp 2 cycles later -> redirect cycle pc_we=1, both flushes; next 2 cycles if_id_flush=1, pc_we=0; response dropped; following cycle normal.
REQ-036 Fetch miss 70000 cycles, CNT_W=16 -> stall_count saturates at 65535.
REQ-037 Assert rst asynchronously during DMEM_WAIT with discard set -> outputs to RUN defaults before next clk edge, stall_count=0.
